// File: rtl/map_table.sv
// -----------------------------------------------------------------------------
// map_table
//   Two-wide register-rename map table, placed directly after the free list in
//   dispatch. Each cycle it translates the architectural sources of both
//   dispatch slots into physical tags. It installs fl_T_1/fl_T_2 as the new
//   destination mappings and returns the previous mapping (Told) for the ROB.
//   A 4-entry checkpoint stack holds full map copies so that a branch
//   mispredict can restore the map in a single cycle. The stack is indexed by
//   marker[1:0], the same way the free list indexes its br_h copies.
//
// Build option
//   MT_READY_BIT_EN : when defined, a per-physical-tag ready vector is kept.
//                     The vector is set by the CDB and cleared on allocation.
//                     It drives the mt_*_rdy outputs, with same-cycle CDB
//                     forwarding. When undefined there is no ready storage,
//                     every mt_*_rdy output is 0 and the cdb_* inputs are
//                     ignored.
//   ZERO_REG        : architectural zero register. It defaults to 31 and is
//                     never renamed.
//
// Ports
//   clock, reset                  clock; synchronous active-high reset
//   D_en_1/2                      dispatch valid per slot
//   id_rega_*/id_regb_*           architectural sources A/B per slot
//   id_dest_*                     architectural destination per slot
//                                 (ZERO_REG = no dest)
//   fl_T_1/2                      new physical tags from the free list
//   cdb_en_*/cdb_tag_*            CDB completion broadcasts
//   br_wr_en_*/br_marker_in_*     take a checkpoint for a branch in that slot
//   br_mispredict/br_mispre_marker  restore the map from a checkpoint
//   mt_T1_*/mt_T2_*               physical tags for sources A/B
//   mt_T1_rdy_*/mt_T2_rdy_*       source-ready flags
//   mt_Told_*                     previous mapping of each destination
// -----------------------------------------------------------------------------
`ifndef ZERO_REG
`define ZERO_REG 5'd31
`endif

module map_table #(
    parameter int NUM_CKPT = 4,
    parameter int ARCH_W   = 5,
    parameter int PHYS_W   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              D_en_1,
    input  logic              D_en_2,
    input  logic [ARCH_W-1:0] id_rega_1,
    input  logic [ARCH_W-1:0] id_rega_2,
    input  logic [ARCH_W-1:0] id_regb_1,
    input  logic [ARCH_W-1:0] id_regb_2,
    input  logic [ARCH_W-1:0] id_dest_1,
    input  logic [ARCH_W-1:0] id_dest_2,
    input  logic [PHYS_W-1:0] fl_T_1,
    input  logic [PHYS_W-1:0] fl_T_2,
    input  logic              cdb_en_1,
    input  logic              cdb_en_2,
    input  logic [PHYS_W-1:0] cdb_tag_1,
    input  logic [PHYS_W-1:0] cdb_tag_2,
    input  logic              br_wr_en_1,
    input  logic              br_wr_en_2,
    input  logic [2:0]        br_marker_in_1,
    input  logic [2:0]        br_marker_in_2,
    input  logic              br_mispredict,
    input  logic [2:0]        br_mispre_marker,
    output logic [PHYS_W-1:0] mt_T1_1,
    output logic [PHYS_W-1:0] mt_T1_2,
    output logic [PHYS_W-1:0] mt_T2_1,
    output logic [PHYS_W-1:0] mt_T2_2,
    output logic              mt_T1_rdy_1,
    output logic              mt_T1_rdy_2,
    output logic              mt_T2_rdy_1,
    output logic              mt_T2_rdy_2,
    output logic [PHYS_W-1:0] mt_Told_1,
    output logic [PHYS_W-1:0] mt_Told_2
);

    localparam int NUM_ARCH = 1 << ARCH_W;
    localparam int NUM_PHYS = 1 << PHYS_W;
    localparam logic [ARCH_W-1:0] ZR = `ZERO_REG;

    typedef logic [NUM_ARCH-1:0][PHYS_W-1:0] map_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < NUM_ARCH; i++) begin
            m[i] = PHYS_W'(i);
        end
        return m;
    endfunction

    map_t map_q, map_d;
    map_t map_s1;   // map after the slot-1 write only
    map_t map_s2;   // map after both slot writes
    map_t ckpt_q [NUM_CKPT];
    map_t ckpt_d [NUM_CKPT];

    logic wr_1, wr_2;
    logic byp_a2, byp_b2, byp_told2;

    // The marker MSB is a wrap bit used by the free list; it is not needed here.
    logic unused_ok;

    assign wr_1 = D_en_1 && (id_dest_1 != ZR);
    assign wr_2 = D_en_2 && (id_dest_2 != ZR);

    // Intra-group bypass: slot 2 sees slot 1's new tag. wr_1 already excludes
    // the zero register, so a zero source in slot 2 can never match here.
    assign byp_a2    = wr_1 && (id_rega_2 == id_dest_1);
    assign byp_b2    = wr_1 && (id_regb_2 == id_dest_1);
    assign byp_told2 = wr_1 && (id_dest_2 == id_dest_1);

    assign mt_T1_1   = map_q[id_rega_1];
    assign mt_T2_1   = map_q[id_regb_1];
    assign mt_T1_2   = byp_a2 ? fl_T_1 : map_q[id_rega_2];
    assign mt_T2_2   = byp_b2 ? fl_T_1 : map_q[id_regb_2];
    assign mt_Told_1 = map_q[id_dest_1];
    assign mt_Told_2 = byp_told2 ? fl_T_1 : map_q[id_dest_2];

    always_comb begin
        map_s1 = map_q;
        if (wr_1) begin
            map_s1[id_dest_1] = fl_T_1;
        end
        map_s2 = map_s1;
        if (wr_2) begin
            map_s2[id_dest_2] = fl_T_2;
        end
    end

    // A mispredict drops the whole dispatch group, including its checkpoints.
    // Both slots requesting a checkpoint is illegal and writes nothing.
    always_comb begin
        map_d  = map_s2;
        ckpt_d = ckpt_q;
        if (br_mispredict) begin
            map_d = ckpt_q[br_mispre_marker[1:0]];
        end else if (br_wr_en_1 && !br_wr_en_2) begin
            ckpt_d[br_marker_in_1[1:0]] = map_s1;
        end else if (br_wr_en_2 && !br_wr_en_1) begin
            ckpt_d[br_marker_in_2[1:0]] = map_s2;
        end
    end

    // Checkpoints are also cleared on reset so that nothing survives a reset
    // issued in the middle of operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            map_q <= identity_map();
            for (int c = 0; c < NUM_CKPT; c++) begin
                ckpt_q[c] <= identity_map();
            end
        end else begin
            map_q <= map_d;
            for (int c = 0; c < NUM_CKPT; c++) begin
                ckpt_q[c] <= ckpt_d[c];
            end
        end
    end

`ifdef MT_READY_BIT_EN
    logic [NUM_PHYS-1:0] prf_rdy_q, prf_rdy_d;
    logic [NUM_PHYS-1:0] cdb_set;
    logic [NUM_PHYS-1:0] rdy_now;

    assign cdb_set = (cdb_en_1 ? (NUM_PHYS'(1) << cdb_tag_1) : '0)
                   | (cdb_en_2 ? (NUM_PHYS'(1) << cdb_tag_2) : '0);

    // rdy_now includes same-cycle CDB forwarding for the lookups.
    assign rdy_now = prf_rdy_q | cdb_set;

    assign mt_T1_rdy_1 = (id_rega_1 == ZR) || rdy_now[map_q[id_rega_1]];
    assign mt_T2_rdy_1 = (id_regb_1 == ZR) || rdy_now[map_q[id_regb_1]];
    assign mt_T1_rdy_2 = !byp_a2 && ((id_rega_2 == ZR) || rdy_now[map_q[id_rega_2]]);
    assign mt_T2_rdy_2 = !byp_b2 && ((id_regb_2 == ZR) || rdy_now[map_q[id_regb_2]]);

    // Allocation clears are applied after the CDB sets so that they win.
    // Ready bits are not checkpointed: squashed tags are cleared again when
    // they are reallocated.
    always_comb begin
        prf_rdy_d = rdy_now;
        if (!br_mispredict) begin
            if (wr_1) begin
                prf_rdy_d[fl_T_1] = 1'b0;
            end
            if (wr_2) begin
                prf_rdy_d[fl_T_2] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prf_rdy_q <= '1;
        end else begin
            prf_rdy_q <= prf_rdy_d;
        end
    end

    assign unused_ok = ^{br_marker_in_1[2], br_marker_in_2[2], br_mispre_marker[2]};
`else
    assign mt_T1_rdy_1 = 1'b0;
    assign mt_T2_rdy_1 = 1'b0;
    assign mt_T1_rdy_2 = 1'b0;
    assign mt_T2_rdy_2 = 1'b0;

    assign unused_ok = ^{br_marker_in_1[2], br_marker_in_2[2], br_mispre_marker[2],
                         cdb_en_1, cdb_en_2, cdb_tag_1, cdb_tag_2};
`endif

endmodule

// File: tb/tb_map_table.sv
module tb_map_table;

    localparam int ZR = 31;
`ifdef MT_READY_BIT_EN
    localparam bit RDY_EN = 1'b1;
`else
    localparam bit RDY_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       D_en_1, D_en_2;
    logic [4:0] id_rega_1, id_rega_2, id_regb_1, id_regb_2, id_dest_1, id_dest_2;
    logic [5:0] fl_T_1, fl_T_2;
    logic       cdb_en_1, cdb_en_2;
    logic [5:0] cdb_tag_1, cdb_tag_2;
    logic       br_wr_en_1, br_wr_en_2;
    logic [2:0] br_marker_in_1, br_marker_in_2;
    logic       br_mispredict;
    logic [2:0] br_mispre_marker;
    logic [5:0] mt_T1_1, mt_T1_2, mt_T2_1, mt_T2_2, mt_Told_1, mt_Told_2;
    logic       mt_T1_rdy_1, mt_T1_rdy_2, mt_T2_rdy_1, mt_T2_rdy_2;

    always #5 clock = ~clock;

    map_table dut (
        .clock(clock), .reset(reset),
        .D_en_1(D_en_1), .D_en_2(D_en_2),
        .id_rega_1(id_rega_1), .id_rega_2(id_rega_2),
        .id_regb_1(id_regb_1), .id_regb_2(id_regb_2),
        .id_dest_1(id_dest_1), .id_dest_2(id_dest_2),
        .fl_T_1(fl_T_1), .fl_T_2(fl_T_2),
        .cdb_en_1(cdb_en_1), .cdb_en_2(cdb_en_2),
        .cdb_tag_1(cdb_tag_1), .cdb_tag_2(cdb_tag_2),
        .br_wr_en_1(br_wr_en_1), .br_wr_en_2(br_wr_en_2),
        .br_marker_in_1(br_marker_in_1), .br_marker_in_2(br_marker_in_2),
        .br_mispredict(br_mispredict), .br_mispre_marker(br_mispre_marker),
        .mt_T1_1(mt_T1_1), .mt_T1_2(mt_T1_2), .mt_T2_1(mt_T2_1), .mt_T2_2(mt_T2_2),
        .mt_T1_rdy_1(mt_T1_rdy_1), .mt_T1_rdy_2(mt_T1_rdy_2),
        .mt_T2_rdy_1(mt_T2_rdy_1), .mt_T2_rdy_2(mt_T2_rdy_2),
        .mt_Told_1(mt_Told_1), .mt_Told_2(mt_Told_2)
    );

    typedef struct {
        bit       rst, d1, d2;
        bit [4:0] a1, b1, dst1, a2, b2, dst2;
        bit [5:0] t1, t2;
        bit       c1, c2;
        bit [5:0] ct1, ct2;
        bit       bw1, bw2;
        bit [2:0] bm1, bm2;
        bit       mis;
        bit [2:0] mm;
    } stim_t;

    typedef struct {
        int ta1, tb1, ta2, tb2;
        bit ra1, rb1, ra2, rb2;
        int told1, told2;
        bit ck1, ck2;
    } exp_t;

    // Reference state: architectural map, tag readiness, checkpoint copies.
    int mref [32];
    bit pref [64];
    int cref [4][32];
    bit cval [4];

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Expected tag/ready of one source, straight from the renaming rules.
    task automatic src_expect(input int slot, input bit [4:0] r, input stim_t s,
                              output int tag, output bit rdy);
        if (r == ZR) begin
            tag = mref[ZR];
            rdy = 1'b1;
        end else if (slot == 2 && s.d1 && s.dst1 != ZR && r == s.dst1) begin
            tag = s.t1;
            rdy = 1'b0;
        end else begin
            tag = mref[r];
            rdy = pref[tag] || (s.c1 && s.ct1 == tag) || (s.c2 && s.ct2 == tag);
        end
        rdy = rdy & RDY_EN;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mref[i] = i;
        for (int i = 0; i < 64; i++) pref[i] = 1'b1;
        for (int c = 0; c < 4; c++) cval[c] = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        if (s.rst) begin
            model_reset();
        end else begin
            if (s.c1) pref[s.ct1] = 1'b1;
            if (s.c2) pref[s.ct2] = 1'b1;
            if (s.mis) begin
                for (int i = 0; i < 32; i++) mref[i] = cref[s.mm[1:0]][i];
            end else begin
                if (s.d1 && s.dst1 != ZR) begin
                    mref[s.dst1] = s.t1;
                    pref[s.t1]   = 1'b0;
                end
                if (s.bw1 && !s.bw2) begin
                    for (int i = 0; i < 32; i++) cref[s.bm1[1:0]][i] = mref[i];
                    cval[s.bm1[1:0]] = 1'b1;
                end
                if (s.d2 && s.dst2 != ZR) begin
                    mref[s.dst2] = s.t2;
                    pref[s.t2]   = 1'b0;
                end
                if (s.bw2 && !s.bw1) begin
                    for (int i = 0; i < 32; i++) cref[s.bm2[1:0]][i] = mref[i];
                    cval[s.bm2[1:0]] = 1'b1;
                end
            end
        end
    endtask

    // Called just after a rising edge: drive, predict, advance the model, wait a cycle.
    task automatic apply(input stim_t s);
        exp_t e;
        reset = s.rst;
        D_en_1 = s.d1;  D_en_2 = s.d2;
        id_rega_1 = s.a1;  id_regb_1 = s.b1;  id_dest_1 = s.dst1;
        id_rega_2 = s.a2;  id_regb_2 = s.b2;  id_dest_2 = s.dst2;
        fl_T_1 = s.t1;  fl_T_2 = s.t2;
        cdb_en_1 = s.c1;  cdb_en_2 = s.c2;  cdb_tag_1 = s.ct1;  cdb_tag_2 = s.ct2;
        br_wr_en_1 = s.bw1;  br_wr_en_2 = s.bw2;
        br_marker_in_1 = s.bm1;  br_marker_in_2 = s.bm2;
        br_mispredict = s.mis;  br_mispre_marker = s.mm;
        if (!s.rst) begin
            src_expect(1, s.a1, s, e.ta1, e.ra1);
            src_expect(1, s.b1, s, e.tb1, e.rb1);
            src_expect(2, s.a2, s, e.ta2, e.ra2);
            src_expect(2, s.b2, s, e.tb2, e.rb2);
            e.told1 = mref[s.dst1];
            e.told2 = (s.d1 && s.dst1 != ZR && s.dst2 == s.dst1) ? int'(s.t1) : mref[s.dst2];
            e.ck1 = s.d1 && s.dst1 != ZR;
            e.ck2 = s.d2 && s.dst2 != ZR;
            sbq.push_back(e);
        end
        model_step(s);
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle whenever a prediction is pending.
    initial begin
        exp_t m;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                m = sbq.pop_front();
                check("T1_1", mt_T1_1, m.ta1);
                check("T2_1", mt_T2_1, m.tb1);
                check("T1_2", mt_T1_2, m.ta2);
                check("T2_2", mt_T2_2, m.tb2);
                check("T1_rdy_1", mt_T1_rdy_1, m.ra1);
                check("T2_rdy_1", mt_T2_rdy_1, m.rb1);
                check("T1_rdy_2", mt_T1_rdy_2, m.ra2);
                check("T2_rdy_2", mt_T2_rdy_2, m.rb2);
                if (m.ck1) check("Told_1", mt_Told_1, m.told1);
                if (m.ck2) check("Told_2", mt_Told_2, m.told2);
            end
        end
    end

    function automatic bit [4:0] rreg();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 5'(ZR);
        if (r < 11) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    idx;

        s = idle();
        s.rst = 1'b1;
        apply(s);
        apply(s);

        // Reset identity map and ready state.
        s = idle(); s.a1 = 5; s.b1 = 0; s.a2 = 31; s.b2 = 10; apply(s);
        // Rename r3 -> 32, then look it up.
        s = idle(); s.d1 = 1; s.dst1 = 3; s.t1 = 32; apply(s);
        s = idle(); s.a1 = 3; apply(s);
        // CDB forwarding in the same cycle, then the ready bit persists.
        s = idle(); s.a1 = 3; s.c1 = 1; s.ct1 = 32; apply(s);
        s = idle(); s.a1 = 3; s.b2 = 3; apply(s);
        // Intra-group bypass and Told bypass, same dest in both slots.
        s = idle(); s.d1 = 1; s.dst1 = 7; s.t1 = 40;
        s.d2 = 1; s.a2 = 7; s.b2 = 7; s.dst2 = 7; s.t2 = 41; apply(s);
        s = idle(); s.a1 = 7; s.b1 = 3; apply(s);
        // Slot-2 checkpoint, later dispatch, then restore with a dropped write.
        s = idle(); s.d1 = 1; s.dst1 = 4; s.t1 = 33;
        s.d2 = 1; s.dst2 = 6; s.t2 = 34; s.bw2 = 1; s.bm2 = 3'd2; apply(s);
        s = idle(); s.d1 = 1; s.dst1 = 4; s.t1 = 35; s.a1 = 4; apply(s);
        s = idle(); s.mis = 1; s.mm = 3'd2; s.d1 = 1; s.dst1 = 5; s.t1 = 36; s.a1 = 4; apply(s);
        s = idle(); s.a1 = 4; s.b1 = 6; s.a2 = 5; s.b2 = 4; apply(s);
        // Slot-1 checkpoint excludes the slot-2 write to the same dest.
        s = idle(); s.d1 = 1; s.dst1 = 9; s.t1 = 44;
        s.d2 = 1; s.dst2 = 9; s.t2 = 45; s.bw1 = 1; s.bm1 = 3'd5; apply(s);
        s = idle(); s.a1 = 9; apply(s);
        s = idle(); s.mis = 1; s.mm = 3'd1; apply(s);
        s = idle(); s.a1 = 9; s.a2 = 9; apply(s);
        // Zero-register dest is never renamed.
        s = idle(); s.d1 = 1; s.dst1 = 5'(ZR); s.t1 = 50; apply(s);
        s = idle(); s.a1 = 5'(ZR); s.b1 = 5'(ZR); s.a2 = 5'(ZR); apply(s);
        // Reset in mid-operation returns to the identity map.
        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.a1 = 7; s.b1 = 4; s.a2 = 3; s.b2 = 9; apply(s);

        for (int n = 0; n < 800; n++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 299) == 0);
            s.d1   = ($urandom_range(0, 3) != 0);
            s.d2   = ($urandom_range(0, 3) != 0);
            s.a1   = rreg(); s.b1 = rreg(); s.dst1 = rreg();
            s.a2   = rreg(); s.b2 = rreg(); s.dst2 = rreg();
            s.t1   = 6'($urandom_range(0, 63));
            s.t2   = 6'($urandom_range(0, 63));
            s.c1   = ($urandom_range(0, 2) == 0);
            s.c2   = ($urandom_range(0, 2) == 0);
            s.ct1  = $urandom_range(0, 1) ? 6'(mref[rreg()]) : 6'($urandom_range(0, 63));
            s.ct2  = $urandom_range(0, 1) ? 6'(mref[rreg()]) : 6'($urandom_range(0, 63));
            idx    = $urandom_range(0, 9);
            s.bw1  = (idx == 0);
            s.bw2  = (idx == 1);
            s.bm1  = 3'($urandom_range(0, 7));
            s.bm2  = 3'($urandom_range(0, 7));
            idx    = $urandom_range(0, 3);
            if ($urandom_range(0, 11) == 0 && cval[idx]) begin
                s.mis = 1'b1;
                s.mm  = {1'($urandom_range(0, 1)), 2'(idx)};
            end
            apply(s);
        end

        s = idle();
        apply(s);
        @(posedge clock);
        #1;
        check("sbq_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
